// File: rtl/cpu24_pkg.sv
// Shared CPU24 definitions: datapath width, divider FSM states and the divide-by-zero quotient.
package cpu24_pkg;

  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DATA_W-1:0] DIV0_QUOTIENT = {DATA_W{1'b1}};

endpackage

// File: rtl/divide_seq_24bit_if.sv
// Divider request/result bundle between the ALU control FSM (master) and the divider (slave).
// DIV_SIGNED_EN adds the sign_mode request bit.
interface divide_seq_24bit_if #(
  parameter int WIDTH = cpu24_pkg::DATA_W
);
  // Handshake: master raises start with operands; it is taken only while the divider is idle
  // (busy=0 and done=0). busy covers the iteration phase; done pulses one cycle when
  // quotient/remainder/div_by_zero are valid, and they hold until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             sign_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef DIV_SIGNED_EN
  modport master (
    output start, dividend, divisor, sign_mode,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor, sign_mode,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left by one, subtract D when it fits.
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // One guard bit above the partial remainder turns the borrow into the compare result.
  assign shifted = {r_in, q_in[WIDTH-1]};
  assign diff    = shifted - {2'b00, d};
  assign fits    = ~diff[WIDTH+1];

  assign r_out = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign q_out = {q_in[WIDTH-2:0], fits};

endmodule

// File: rtl/divide_seq_24bit.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIV_SIGNED_EN: two's-complement truncating division selected by sign_mode.
module divide_seq_24bit
  import cpu24_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  divide_seq_24bit_if.slave        bus,
  output div_state_t               dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   r_q, r_next;
  logic [WIDTH-1:0] q_q, q_next;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div0_q;

  logic             accept;
  logic             last_iter;
  logic             div0_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign div0_in   = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q_q, neg_r_q;

  assign a_neg = bus.sign_mode & bus.dividend[WIDTH-1];
  assign b_neg = bus.sign_mode & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  // Quotient sign follows the operand signs, remainder keeps the dividend's sign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
    end
  end

  assign q_fin = neg_q_q ? -q_next : q_next;
  assign r_fin = neg_r_q ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fin = q_next;
  assign r_fin = r_next[WIDTH-1:0];
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d     (d_q),
    .r_out (r_next),
    .q_out (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = div0_in ? DONE : RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load only on the edge entering DONE, so they stay stable through RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
    end else if (accept) begin
      r_q   <= '0;
      q_q   <= a_mag;
      d_q   <= b_mag;
      cnt_q <= '0;
      if (div0_in) begin
        quotient_q  <= {WIDTH{1'b1}};
        remainder_q <= bus.dividend;
        div0_q      <= 1'b1;
      end else begin
        div0_q <= 1'b0;
      end
    end else if (state_q == RUN) begin
      r_q   <= r_next;
      q_q   <= q_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        quotient_q  <= q_fin;
        remainder_q <= r_fin;
      end
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div0_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_divide_seq_24bit.sv
// Scoreboard bench for divide_seq_24bit: directed corners plus a random sweep against a
// plain-arithmetic model; signed cases are added when DIV_SIGNED_EN is defined.
module tb_divide_seq_24bit;
  import cpu24_pkg::*;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       reset;
  div_state_t dbg_state;

  divide_seq_24bit_if #(.WIDTH(W)) bus();

  divide_seq_24bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard queues
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic         exp_z_q[$];
  logic         exp_s_q[$];
  int           exp_cyc_q[$];

  logic [W-1:0] hold_q, hold_r;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer division
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, sq, sr;
    z = (b == 0);
    if (z) begin
      q = {W{1'b1}};
      r = a;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // driver
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold_cycles);
    int guard;
    logic [W-1:0] q, r;
    logic z;
    logic [31:0] t;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL idle_wait: got busy/done stuck expected idle within 200 cycles");
      return;
    end
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIV_SIGNED_EN
    bus.sign_mode = s;
`endif
    bus.start = 1'b1;
    model(a, b, s, q, r, z);
    exp_q.push_back(q);
    exp_r_q.push_back(r);
    exp_a_q.push_back(a);
    exp_b_q.push_back(b);
    exp_z_q.push_back(z);
    exp_s_q.push_back(s);
    exp_cyc_q.push_back(cyc + 1 + ((b == 0) ? 0 : W));
    // start held high with fresh operands must not disturb the operation in flight
    for (int i = 1; i < hold_cycles; i++) begin
      @(negedge clk);
      t = $urandom;
      bus.dividend = t[W-1:0];
      t = $urandom;
      bus.divisor = t[W-1:0];
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_r_q.delete();
    exp_a_q.delete();
    exp_b_q.delete();
    exp_z_q.delete();
    exp_s_q.delete();
    exp_cyc_q.delete();
  endtask

  // monitor
  initial begin
    logic [W-1:0]   eq, er, ea, eb;
    logic           ez, es;
    int             ec;
    logic [2*W-1:0] prod;
    hold_q = '0;
    hold_r = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_q = '0;
        hold_r = '0;
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
        end else begin
          eq = exp_q.pop_front();
          er = exp_r_q.pop_front();
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          ez = exp_z_q.pop_front();
          es = exp_s_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_int("done_cycle", cyc, ec);
          check("quotient", bus.quotient, eq);
          check("remainder", bus.remainder, er);
          check("div_by_zero", W'(bus.div_by_zero), W'(ez));
          check("busy_in_done", W'(bus.busy), '0);
          check("state_done", W'(dbg_state == DONE), W'(1));
          if (!ez && !es) begin
            prod = {{W{1'b0}}, bus.quotient} * {{W{1'b0}}, eb} + {{W{1'b0}}, bus.remainder};
            check("invariant", W'(prod == {{W{1'b0}}, ea}), W'(1));
            check("rem_lt_div", W'(bus.remainder < eb), W'(1));
          end
          hold_q = eq;
          hold_r = er;
        end
      end else begin
        check("quotient_stable", bus.quotient, hold_q);
        check("remainder_stable", bus.remainder, hold_r);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got no end of test expected finish before 2ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // stimulus
  initial begin
    logic [31:0]  t;
    logic [W-1:0] a, b;
    logic         s;
    int           sel, guard;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
    bus.sign_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_div0", W'(bus.div_by_zero), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_state", W'(dbg_state == IDLE), W'(1));
    #2 reset = 1'b0;

    issue(24'd100, 24'd7, 1'b0, 1);
    issue(24'hFFFFFF, 24'd1, 1'b0, 1);
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1);
    issue(24'h123456, 24'd0, 1'b0, 1);
    issue(24'd1000, 24'd3, 1'b0, 10);
    issue(24'h123456, 24'd0, 1'b0, 2);
    issue(24'd77, 24'd5, 1'b0, 1);
    issue(24'd5, 24'd9, 1'b0, 1);

    // abort in the middle of RUN
    issue(24'h654321, 24'd9, 1'b0, 1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    flush_sb();
    #1;
    check("abort_quotient", bus.quotient, '0);
    check("abort_remainder", bus.remainder, '0);
    check("abort_div0", W'(bus.div_by_zero), '0);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    @(negedge clk);
    #2 reset = 1'b0;
    issue(24'd50, 24'd5, 1'b0, 1);

`ifdef DIV_SIGNED_EN
    issue(24'hFFFF9C, 24'd7, 1'b1, 1);
    issue(24'd100, 24'hFFFFF9, 1'b1, 1);
    issue(24'hFFFF9C, 24'hFFFFF9, 1'b1, 1);
    issue(24'h800000, 24'hFFFFFF, 1'b1, 1);
    issue(24'hFFFF9C, 24'd0, 1'b1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      t = $urandom;
      a = t[W-1:0];
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel < 5) begin
        t = $urandom_range(1, 255);
        b = t[W-1:0];
      end else begin
        t = $urandom;
        b = t[W-1:0];
      end
`ifdef DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue(a, b, s, (b == 0) ? $urandom_range(1, 2) : $urandom_range(1, 3));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_int("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
